// File: rtl/if_mem_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch memory controller.
package if_mem_ctrl_pkg;

    localparam int unsigned InstW              = 32;
    localparam logic [InstW-1:0] ZeroWord      = '0;
    localparam int unsigned IcacheLinesDefault = 64;

    typedef enum logic [2:0] {
        StIdle,
        StB0,
        StB1,
        StB2,
        StB3
    } if_state_e;

endpackage

// File: rtl/if_mem_ctrl_if.sv
// Fetch bundle: core side (pc/ce/branch in, instruction out) plus byte-wide memory port.
interface if_mem_ctrl_if
    import if_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 17
);
    logic [InstW-1:0]  pc;
    logic              ce;
    logic              branch_flag;
    logic [InstW-1:0]  inst;
    logic              inst_valid;
    logic              stallreq;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_din;

    // The master side represents both the core and the instruction memory.
    modport master (
        output pc, ce, branch_flag, mem_din,
        input  inst, inst_valid, stallreq, mem_addr, mem_rd
    );

    modport slave (
        input  pc, ce, branch_flag, mem_din,
        output inst, inst_valid, stallreq, mem_addr, mem_rd
    );

endinterface

// File: rtl/if_mem_ctrl_icache_tagram.sv
// Direct-mapped one-word-per-line instruction cache storage: combinational lookup, one write port.
module if_mem_ctrl_icache_tagram
    import if_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned LINES  = IcacheLinesDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              hit_o,
    output logic [InstW-1:0]  rd_data_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [InstW-1:0]  wr_data_i
);
    localparam int unsigned IW   = $clog2(LINES);
    localparam int unsigned TagW = ADDR_W - 2 - IW;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TagW-1:0]  tag_q  [LINES];
    logic [TagW-1:0]  tag_d  [LINES];
    logic [InstW-1:0] data_q [LINES];
    logic [InstW-1:0] data_d [LINES];
    logic [IW-1:0]    rd_idx, wr_idx;
    logic             unused_lsb;

    assign rd_idx     = rd_addr_i[2+IW-1:2];
    assign wr_idx     = wr_addr_i[2+IW-1:2];
    assign unused_lsb = ^{rd_addr_i[1:0], wr_addr_i[1:0]};

    assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_addr_i[ADDR_W-1:2+IW]);
    assign rd_data_o = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we_i) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_addr_i[ADDR_W-1:2+IW];
            data_d[wr_idx]  = wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless until the valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/if_mem_ctrl.sv
// Instruction-fetch controller: assembles 32-bit words from four byte reads, stalls until ready.
// Define ICACHE_EN to add a direct-mapped I-cache in front of the byte memory.
module if_mem_ctrl
    import if_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned ICACHE_LINES = IcacheLinesDefault
) (
    input logic          clk,
    input logic          rst,
    if_mem_ctrl_if.slave bus
);
    if_state_e         state_q, state_d;
    logic [InstW-1:0]  pc_q, pc_d;
    logic [InstW-1:0]  inst_q, inst_d;
    logic [23:0]       bytes_q, bytes_d;
    logic              word_valid_q, word_valid_d;
    logic              hit, abort, start, mem_rd, rd_en, fill;
    logic [ADDR_W-1:0] base;
    logic [1:0]        offset;
    logic              cache_hit;
    logic [InstW-1:0]  cache_data;

    assign hit   = word_valid_q && (pc_q == bus.pc);
    assign abort = (state_q != StIdle) && (bus.branch_flag || (bus.pc != pc_q));
    assign start = (state_q == StIdle) && bus.ce && !hit && !bus.branch_flag;

    assign bus.inst_valid = bus.ce && hit;
    assign bus.stallreq   = bus.ce && !hit;
    assign bus.inst       = inst_q;

    // Reset must silence the memory port even before the state has been cleared.
    assign rd_en        = mem_rd && rst;
    assign bus.mem_rd   = rd_en;
    assign bus.mem_addr = rd_en ? (base + ADDR_W'(offset)) : '0;

`ifdef ICACHE_EN
    if_mem_ctrl_icache_tagram #(
        .ADDR_W(ADDR_W),
        .LINES (ICACHE_LINES)
    ) u_tagram (
        .clk      (clk),
        .rst      (rst),
        .rd_addr_i(bus.pc[ADDR_W-1:0]),
        .hit_o    (cache_hit),
        .rd_data_o(cache_data),
        .we_i     (fill && rst),
        .wr_addr_i(pc_q[ADDR_W-1:0]),
        .wr_data_i({bus.mem_din, bytes_q})
    );
`else
    logic unused_cfg;
    assign cache_hit  = 1'b0;
    assign cache_data = ZeroWord;
    assign unused_cfg = ^{ICACHE_LINES, fill};
`endif

    // Read issue and byte capture overlap: each Bk state captures byte k and requests byte k+1.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        bytes_d      = bytes_q;
        word_valid_d = word_valid_q;
        mem_rd       = 1'b0;
        base         = pc_q[ADDR_W-1:0];
        offset       = 2'd0;
        fill         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pc_d = bus.pc;
                    if (cache_hit) begin
                        inst_d       = cache_data;
                        word_valid_d = 1'b1;
                    end else begin
                        word_valid_d = 1'b0;
                        mem_rd       = 1'b1;
                        base         = bus.pc[ADDR_W-1:0];
                        state_d      = StB0;
                    end
                end
            end
            StB0: begin
                bytes_d[7:0] = bus.mem_din;
                mem_rd       = 1'b1;
                offset       = 2'd1;
                state_d      = StB1;
            end
            StB1: begin
                bytes_d[15:8] = bus.mem_din;
                mem_rd        = 1'b1;
                offset        = 2'd2;
                state_d       = StB2;
            end
            StB2: begin
                bytes_d[23:16] = bus.mem_din;
                mem_rd         = 1'b1;
                offset         = 2'd3;
                state_d        = StB3;
            end
            StB3: begin
                inst_d       = {bus.mem_din, bytes_q};
                word_valid_d = 1'b1;
                fill         = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Abort beats completion: nothing from the interrupted fetch becomes visible.
        if (abort) begin
            state_d      = StIdle;
            word_valid_d = 1'b0;
            inst_d       = inst_q;
            bytes_d      = bytes_q;
            mem_rd       = 1'b0;
            fill         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            inst_q       <= ZeroWord;
            bytes_q      <= '0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            bytes_q      <= bytes_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule
